// File: rtl/condicionador_entradas.sv
// Input conditioning for the lamp controller: synchronizes, debounces and classifies the push-button
// and presence sensor into single-cycle commands. Sensor path is compiled in with COND_PRESENCA_EN.
module condicionador_entradas #(
  parameter int unsigned DEBOUNCE_CYC   = 100,
  parameter int unsigned LONG_PRESS_CYC = 3000,
  parameter int unsigned TIMEOUT_CYC    = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned LpW = $clog2(LONG_PRESS_CYC + 1);

  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYC);
  localparam logic [DbW-1:0] DbOne = DbW'(1);
  localparam logic [LpW-1:0] LpMax = LpW'(LONG_PRESS_CYC);
  localparam logic [LpW-1:0] LpOne = LpW'(1);

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_CONFIRMA,
    BT_PRESSIONADO,
    BT_LONGO
  } bt_state_e;

  logic           btn_meta_q;
  logic           btn_s;
  bt_state_e      bt_q;
  logic [DbW-1:0] deb_q;
  logic [DbW-1:0] rel_q;
  logic [LpW-1:0] hold_q;
  logic [DbW-1:0] deb_inc;
  logic [DbW-1:0] rel_nxt;
  logic [LpW-1:0] hold_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q <= 1'b0;
      btn_s      <= 1'b0;
    end else begin
      btn_meta_q <= push_button;
      btn_s      <= btn_meta_q;
    end
  end

  // Saturating next values; decisions are taken on the value being loaded this edge.
  always_comb begin
    deb_inc  = (deb_q == DbMax) ? deb_q : deb_q + DbOne;
    rel_nxt  = btn_s ? '0 : ((rel_q == DbMax) ? rel_q : rel_q + DbOne);
    hold_inc = (hold_q == LpMax) ? hold_q : hold_q + LpOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bt_q   <= BT_IDLE;
      deb_q  <= '0;
      rel_q  <= '0;
      hold_q <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
    end else begin
      a <= 1'b0;
      b <= 1'b0;
      unique case (bt_q)
        BT_IDLE: begin
          if (btn_s) begin
            bt_q  <= BT_CONFIRMA;
            deb_q <= DbOne;
          end
        end
        BT_CONFIRMA: begin
          if (!btn_s) begin
            bt_q  <= BT_IDLE;
            deb_q <= '0;
          end else if (deb_inc == DbMax) begin
            bt_q   <= BT_PRESSIONADO;
            deb_q  <= '0;
            hold_q <= '0;
            rel_q  <= '0;
          end else begin
            deb_q <= deb_inc;
          end
        end
        BT_PRESSIONADO: begin
          hold_q <= hold_inc;
          rel_q  <= rel_nxt;
          // A completed release wins over a hold that matures on the same edge.
          if (rel_nxt == DbMax) begin
            b      <= 1'b1;
            bt_q   <= BT_IDLE;
            rel_q  <= '0;
            hold_q <= '0;
          end else if (hold_inc == LpMax) begin
            a    <= 1'b1;
            bt_q <= BT_LONGO;
          end
        end
        BT_LONGO: begin
          rel_q <= rel_nxt;
          if (rel_nxt == DbMax) begin
            bt_q   <= BT_IDLE;
            rel_q  <= '0;
            hold_q <= '0;
          end
        end
        default: bt_q <= BT_IDLE;
      endcase
    end
  end

`ifdef COND_PRESENCA_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYC);
  localparam logic [ToW-1:0] ToOne = ToW'(1);

  typedef enum logic [1:0] {
    IR_AUSENTE,
    IR_PRESENTE,
    IR_CONTANDO
  } ir_state_e;

  logic           ir_meta_q;
  logic           ir_s;
  ir_state_e      ir_q;
  logic [DbW-1:0] pres_q;
  logic [ToW-1:0] to_q;
  logic [DbW-1:0] pres_nxt;
  logic [ToW-1:0] to_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_meta_q <= 1'b0;
      ir_s      <= 1'b0;
    end else begin
      ir_meta_q <= infravermelho;
      ir_s      <= ir_meta_q;
    end
  end

  always_comb begin
    pres_nxt = ir_s ? ((pres_q == DbMax) ? pres_q : pres_q + DbOne) : '0;
    to_inc   = (to_q == ToMax) ? to_q : to_q + ToOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q   <= IR_AUSENTE;
      pres_q <= '0;
      to_q   <= '0;
      c      <= 1'b0;
      d      <= 1'b0;
    end else begin
      c <= 1'b0;
      d <= 1'b0;
      unique case (ir_q)
        IR_AUSENTE: begin
          if (pres_nxt == DbMax) begin
            d      <= 1'b1;
            ir_q   <= IR_PRESENTE;
            pres_q <= '0;
          end else begin
            pres_q <= pres_nxt;
          end
        end
        IR_PRESENTE: begin
          if (!ir_s) begin
            ir_q <= IR_CONTANDO;
            to_q <= ToOne;
          end
        end
        IR_CONTANDO: begin
          if (ir_s) begin
            ir_q <= IR_PRESENTE;
            to_q <= '0;
          end else if (to_inc == ToMax) begin
            c    <= 1'b1;
            ir_q <= IR_AUSENTE;
            to_q <= '0;
          end else begin
            to_q <= to_inc;
          end
        end
        default: ir_q <= IR_AUSENTE;
      endcase
    end
  end
`else
  logic unused_ir;
  assign unused_ir = infravermelho;
  assign c = 1'b0;
  assign d = 1'b0;
`endif

endmodule

// File: tb/tb_condicionador_entradas.sv
// Randomized and directed bench for condicionador_entradas against a run-length behavioural model.
module tb_condicionador_entradas;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;
  localparam int unsigned T = 16;
`ifdef COND_PRESENCA_EN
  localparam bit PresEn = 1'b1;
`else
  localparam bit PresEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_button = 1'b0;
  logic infravermelho = 1'b0;
  logic a, b, c, d;

  always #5 clk = ~clk;

  condicionador_entradas #(
    .DEBOUNCE_CYC  (D),
    .LONG_PRESS_CYC(L),
    .TIMEOUT_CYC   (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .a            (a),
    .b            (b),
    .c            (c),
    .d            (d)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: two-stage delay for the synchronizers, then run lengths of the synchronized levels.
  int m_bd1, m_bd2, m_id1, m_id2;
  int b_ones, b_zeros, i_ones, i_zeros;
  int b_mode;  // 0 waiting, 1 pressed, 2 long press held
  int b_t0;
  int i_pres;
  bit exp_a, exp_b, exp_c, exp_d;
  int edge_n = 0;

  int cnt_a, cnt_b, cnt_c, cnt_d;
  int last_a, last_b, last_c, last_d;

  task automatic model_reset();
    m_bd1 = 0; m_bd2 = 0; m_id1 = 0; m_id2 = 0;
    b_ones = 0; b_zeros = 0; i_ones = 0; i_zeros = 0;
    b_mode = 0; b_t0 = 0; i_pres = 0;
    exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
  endtask

  task automatic model_step();
    int sb, si;
    sb = m_bd2; m_bd2 = m_bd1; m_bd1 = int'(push_button);
    si = m_id2; m_id2 = m_id1; m_id1 = int'(infravermelho);
    if (sb != 0) begin b_ones++; b_zeros = 0; end else begin b_zeros++; b_ones = 0; end
    if (si != 0) begin i_ones++; i_zeros = 0; end else begin i_zeros++; i_ones = 0; end
    exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
    if (b_mode == 0) begin
      if (b_ones == D) begin b_mode = 1; b_t0 = edge_n; end
    end else if (b_mode == 1) begin
      if (b_zeros == D) begin exp_b = 1; b_mode = 0; end
      else if (edge_n - b_t0 == L) begin exp_a = 1; b_mode = 2; end
    end else begin
      if (b_zeros == D) b_mode = 0;
    end
    if (PresEn) begin
      if (i_pres == 0) begin
        if (i_ones == D) begin exp_d = 1; i_pres = 1; end
      end else if (i_zeros == T) begin
        exp_c = 1; i_pres = 0;
      end
    end
  endtask

  task automatic clear_counts();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    last_a = -1; last_b = -1; last_c = -1; last_d = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rst) model_step();
    else begin exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0; end
    #1;
    check_eq($sformatf("a@%0d", edge_n), 32'(a), 32'(exp_a));
    check_eq($sformatf("b@%0d", edge_n), 32'(b), 32'(exp_b));
    check_eq($sformatf("c@%0d", edge_n), 32'(c), 32'(exp_c));
    check_eq($sformatf("d@%0d", edge_n), 32'(d), 32'(exp_d));
    if (a === 1'b1) begin cnt_a++; last_a = edge_n; end
    if (b === 1'b1) begin cnt_b++; last_b = edge_n; end
    if (c === 1'b1) begin cnt_c++; last_c = edge_n; end
    if (d === 1'b1) begin cnt_d++; last_d = edge_n; end
  endtask

  task automatic hold(input int k);
    repeat (k) tick();
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before the next clock edge.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_eq({tag, "_a"}, 32'(a), 32'd0);
    check_eq({tag, "_b"}, 32'(b), 32'd0);
    check_eq({tag, "_c"}, 32'(c), 32'd0);
    check_eq({tag, "_d"}, 32'(d), 32'd0);
    model_reset();
    hold(2);
    rst = 1'b1;
  endtask

  initial begin
    int r, rel, f, bl, il;
    model_reset();
    clear_counts();
    #1 rst = 1'b0;
    hold(3);
    rst = 1'b1;

    // Short press: b six edges after release.
    clear_counts();
    push_button = 1'b1; r = edge_n;
    hold(10);
    push_button = 1'b0; rel = edge_n;
    hold(12);
    check_eq("short_b_cnt", cnt_b, 1);
    check_eq("short_b_lat", last_b - rel, 6);
    check_eq("short_a_cnt", cnt_a, 0);

    // Long press: single a at rise + 26, no b at release, then a normal short press.
    clear_counts();
    push_button = 1'b1; r = edge_n;
    hold(40);
    push_button = 1'b0;
    hold(12);
    check_eq("long_a_cnt", cnt_a, 1);
    check_eq("long_a_lat", last_a - r, 26);
    check_eq("long_b_cnt", cnt_b, 0);
    clear_counts();
    push_button = 1'b1;
    hold(10);
    push_button = 1'b0; rel = edge_n;
    hold(12);
    check_eq("after_long_b", last_b - rel, 6);
    check_eq("after_long_a", cnt_a, 0);

    // Bounce: 1- and 3-cycle glitches give nothing; a clean press afterwards still works.
    clear_counts();
    push_button = 1'b1; hold(1);
    push_button = 1'b0; hold(3);
    push_button = 1'b1; hold(3);
    push_button = 1'b0; hold(12);
    check_eq("bounce_pulses", cnt_a + cnt_b, 0);
    push_button = 1'b1; hold(10);
    push_button = 1'b0; rel = edge_n;
    hold(12);
    check_eq("bounce_then_b", last_b - rel, 6);

    // Presence with re-trigger inside the timeout.
    clear_counts();
    infravermelho = 1'b1; r = edge_n; hold(10);
    infravermelho = 1'b0; hold(8);
    infravermelho = 1'b1; hold(5);
    infravermelho = 1'b0; f = edge_n; hold(30);
    check_eq("ir_d_cnt", cnt_d, PresEn ? 1 : 0);
    check_eq("ir_d_edge", last_d, PresEn ? r + 6 : -1);
    check_eq("ir_c_cnt", cnt_c, PresEn ? 1 : 0);
    check_eq("ir_c_edge", last_c, PresEn ? f + 18 : -1);

    // Reset with button pressed and sensor counting down.
    infravermelho = 1'b1; hold(8);
    infravermelho = 1'b0; push_button = 1'b1; hold(8);
    push_button = 1'b0;
    reset_pulse("rst_mid");
    clear_counts();
    hold(40);
    check_eq("post_rst_pulses", cnt_a + cnt_b + cnt_c + cnt_d, 0);

    // Random bursts, glitches and occasional resets, every cycle compared to the model.
    bl = 0; il = 0;
    for (int i = 0; i < 4000; i++) begin
      if (bl == 0) begin
        push_button = ~push_button;
        bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
      end
      if (il == 0) begin
        infravermelho = ~infravermelho;
        il = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      end
      bl--;
      il--;
      if (i % 1000 == 999) reset_pulse("rst_rand");
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
